// File: rtl/game_timer_ctrl.sv
// Countdown timer and score-sum controller shared by every timed game mode.
// Sums NUM_CH score channels, grants milestone/reward time bonuses, handles pause/stop and latches the final score.
module game_timer_ctrl #(
  parameter int NUM_CH          = 4,
  parameter int SCORE_W         = 7,
  parameter int TIMER_W         = 6,
  parameter int TIMER_INIT      = 16,
  parameter int TIMER_MAX       = 16,
  parameter int TICK_DIV        = 50000000,
  parameter int MILESTONE_STEP  = 5,
  parameter int MILESTONE_BONUS = 1,
  parameter int REWARD_BONUS    = 3,
  localparam int SUM_W          = SCORE_W + $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_game,
  input  logic                      btn_stop,
  input  logic                      btn_pause,
  input  logic                      btn_return,
  input  logic [NUM_CH*SCORE_W-1:0] score_in,
  input  logic                      reward_addtime,
  output logic [TIMER_W-1:0]        timer,
  output logic [15:0]               seg_out,
  output logic [15:0]               led_out,
  output logic                      gameover,
  output logic [SUM_W-1:0]          score_final,
  output logic [1:0]                state
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_W   = SUM_W + $clog2(MILESTONE_STEP + 1) + 1;
  localparam int EXT_W  = TIMER_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  logic [1:0]         r_state, w_state_d;
  logic [TIMER_W-1:0] r_timer, w_timer_d;
  logic [TICK_W-1:0]  r_tick, w_tick_d, w_run_tick;
  logic [MS_W-1:0]    r_next_ms, w_next_ms_d;
  logic [SUM_W-1:0]   r_sum, w_sum_d, w_sum_in;
  logic [SUM_W-1:0]   r_final, w_final_d;
  logic               r_gameover, w_gameover_d;
  logic               r_reward_q;
  logic [15:0]        r_seg, r_led, w_led_d;
  logic               w_dec, w_ms_hit, w_rew_edge;
  logic [EXT_W-1:0]   w_bonus, w_raised, w_capped, w_run_timer;

  always_comb begin
    w_sum_in = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum_in = w_sum_in + SUM_W'(score_in[i*SCORE_W +: SCORE_W]);
    end
  end

  // Candidate timer/tick for a RUN cycle: bonuses saturate at TIMER_MAX before the tick decrement.
  always_comb begin
    w_rew_edge = reward_addtime & ~r_reward_q;
    w_ms_hit   = (MS_W'(r_sum) >= r_next_ms);
    w_dec      = (r_tick == TICK_W'(TICK_DIV - 1));
    w_run_tick = w_dec ? '0 : r_tick + TICK_W'(1);
    if (r_timer != '0) begin
      w_bonus = (w_ms_hit ? EXT_W'(MILESTONE_BONUS) : EXT_W'(0)) +
                (w_rew_edge ? EXT_W'(REWARD_BONUS) : EXT_W'(0));
    end else begin
      w_bonus = '0;
    end
    w_raised = EXT_W'(r_timer) + w_bonus;
    w_capped = (w_raised > EXT_W'(TIMER_MAX)) ? EXT_W'(TIMER_MAX) : w_raised;
    if (w_dec && (w_capped != '0)) begin
      w_run_timer = w_capped - EXT_W'(1);
    end else begin
      w_run_timer = w_capped;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_timer_d    = r_timer;
    w_tick_d     = r_tick;
    w_next_ms_d  = r_next_ms;
    w_sum_d      = r_sum;
    w_final_d    = r_final;
    w_gameover_d = r_gameover;
    case (r_state)
      ST_IDLE: begin
        w_timer_d    = TIMER_W'(TIMER_INIT);
        w_tick_d     = '0;
        w_gameover_d = 1'b0;
        if (enable_game) begin
          w_state_d   = ST_RUN;
          w_next_ms_d = MS_W'(MILESTONE_STEP);
          w_sum_d     = w_sum_in;
          w_final_d   = '0;
        end else if (btn_return) begin
          w_sum_d = '0;
        end else begin
          w_sum_d = r_sum;
        end
      end
      ST_RUN: begin
        w_sum_d = w_sum_in;
        if (!enable_game) begin
          w_state_d    = ST_IDLE;
          w_timer_d    = TIMER_W'(TIMER_INIT);
          w_tick_d     = '0;
          w_gameover_d = 1'b0;
        end else if (btn_stop || (w_run_timer == '0)) begin
          w_state_d    = ST_OVER;
          w_timer_d    = TIMER_W'(TIMER_INIT);
          w_tick_d     = '0;
          w_final_d    = w_sum_in;
          w_gameover_d = 1'b1;
        end else begin
          w_timer_d   = TIMER_W'(w_run_timer);
          w_tick_d    = w_run_tick;
          w_next_ms_d = w_ms_hit ? (r_next_ms + MS_W'(MILESTONE_STEP)) : r_next_ms;
          w_state_d   = btn_pause ? ST_PAUSE : ST_RUN;
        end
      end
      ST_PAUSE: begin
        w_sum_d = w_sum_in;
        if (!enable_game) begin
          w_state_d    = ST_IDLE;
          w_timer_d    = TIMER_W'(TIMER_INIT);
          w_tick_d     = '0;
          w_gameover_d = 1'b0;
        end else if (btn_stop) begin
          w_state_d    = ST_OVER;
          w_timer_d    = TIMER_W'(TIMER_INIT);
          w_tick_d     = '0;
          w_final_d    = w_sum_in;
          w_gameover_d = 1'b1;
        end else if (btn_pause) begin
          w_state_d = ST_RUN;
        end else begin
          w_state_d = ST_PAUSE;
        end
      end
      ST_OVER: begin
        if (!enable_game) begin
          w_state_d    = ST_IDLE;
          w_gameover_d = 1'b0;
        end else begin
          w_state_d = ST_OVER;
        end
      end
      default: begin
        w_state_d    = ST_IDLE;
        w_timer_d    = TIMER_W'(TIMER_INIT);
        w_tick_d     = '0;
        w_gameover_d = 1'b0;
      end
    endcase
  end

  // LED thermometer follows the next timer value so it lines up with the timer register.
  always_comb begin
    w_led_d = '0;
    for (int i = 0; i < 16; i++) begin
      w_led_d[i] = (int'(w_timer_d) > i) && (i < TIMER_MAX);
    end
  end

  // State and datapath registers; every output is driven directly from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= TIMER_W'(TIMER_INIT);
      r_tick     <= '0;
      r_next_ms  <= MS_W'(MILESTONE_STEP);
      r_sum      <= '0;
      r_final    <= '0;
      r_gameover <= 1'b0;
      r_reward_q <= 1'b0;
      r_seg      <= '0;
      r_led      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_timer    <= w_timer_d;
      r_tick     <= w_tick_d;
      r_next_ms  <= w_next_ms_d;
      r_sum      <= w_sum_d;
      r_final    <= w_final_d;
      r_gameover <= w_gameover_d;
      r_reward_q <= reward_addtime;
      r_seg      <= 16'(w_sum_d);
      r_led      <= w_led_d;
    end
  end

  assign state       = r_state;
  assign timer       = r_timer;
  assign seg_out     = r_seg;
  assign led_out     = r_led;
  assign gameover    = r_gameover;
  assign score_final = r_final;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed scenarios plus random traffic,
// every cycle compared against an integer-arithmetic model of the game rules.
module tb_game_timer_ctrl;
  localparam int NUM_CH   = 4;
  localparam int SCORE_W  = 7;
  localparam int TIMER_W  = 6;
  localparam int T_INIT   = 3;
  localparam int T_MAX    = 16;
  localparam int TICK_DIV = 4;
  localparam int MS_STEP  = 5;
  localparam int MS_BONUS = 1;
  localparam int RW_BONUS = 3;
  localparam int SUM_W    = SCORE_W + $clog2(NUM_CH);

  logic clk = 1'b0;
  logic rst_n, enable_game, btn_stop, btn_pause, btn_return, reward_addtime;
  logic [NUM_CH*SCORE_W-1:0] score_in;
  logic [TIMER_W-1:0] timer;
  logic [15:0] seg_out, led_out;
  logic gameover;
  logic [SUM_W-1:0] score_final;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: game phase 0 idle, 1 run, 2 pause, 3 over (matches the state output code).
  int m_phase, m_timer, m_cycles, m_next_ms, m_sum, m_final, m_go, m_rew_prev;
  logic [15:0] m_led;

  game_timer_ctrl #(
    .NUM_CH(NUM_CH), .SCORE_W(SCORE_W), .TIMER_W(TIMER_W), .TIMER_INIT(T_INIT),
    .TIMER_MAX(T_MAX), .TICK_DIV(TICK_DIV), .MILESTONE_STEP(MS_STEP),
    .MILESTONE_BONUS(MS_BONUS), .REWARD_BONUS(RW_BONUS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_game(enable_game), .btn_stop(btn_stop),
    .btn_pause(btn_pause), .btn_return(btn_return), .score_in(score_in),
    .reward_addtime(reward_addtime), .timer(timer), .seg_out(seg_out),
    .led_out(led_out), .gameover(gameover), .score_final(score_final), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_leave_to_idle();
    m_phase  = 0;
    m_timer  = T_INIT;
    m_cycles = 0;
    m_go     = 0;
  endtask

  task automatic m_end_game(input int s);
    m_phase  = 3;
    m_timer  = T_INIT;
    m_cycles = 0;
    m_final  = s;
    m_go     = 1;
  endtask

  task automatic model_step();
    int sin, edge_seen, hit, grant, raised, ticked, after;
    sin = 0;
    for (int i = 0; i < NUM_CH; i++) sin += int'(score_in[i*SCORE_W +: SCORE_W]);
    if (!rst_n) begin
      m_phase = 0; m_timer = T_INIT; m_cycles = 0; m_next_ms = MS_STEP;
      m_sum = 0; m_final = 0; m_go = 0; m_rew_prev = 0; m_led = '0;
      return;
    end
    edge_seen  = (reward_addtime && (m_rew_prev == 0)) ? 1 : 0;
    m_rew_prev = reward_addtime ? 1 : 0;
    case (m_phase)
      0: begin
        m_timer = T_INIT; m_cycles = 0; m_go = 0;
        if (enable_game) begin
          m_phase = 1; m_next_ms = MS_STEP; m_sum = sin; m_final = 0;
        end else if (btn_return) begin
          m_sum = 0;
        end
      end
      1: begin
        hit    = (m_sum >= m_next_ms) ? 1 : 0;
        grant  = (m_timer == 0) ? 0 : hit * MS_BONUS + edge_seen * RW_BONUS;
        raised = (m_timer + grant > T_MAX) ? T_MAX : m_timer + grant;
        ticked = ((m_cycles + 1) % TICK_DIV == 0) ? 1 : 0;
        after  = (raised - ticked < 0) ? 0 : raised - ticked;
        m_sum  = sin;
        if (!enable_game) m_leave_to_idle();
        else if (btn_stop || after == 0) m_end_game(sin);
        else begin
          m_timer  = after;
          m_cycles = (m_cycles + 1) % TICK_DIV;
          if (hit != 0) m_next_ms += MS_STEP;
          if (btn_pause) m_phase = 2;
        end
      end
      2: begin
        m_sum = sin;
        if (!enable_game) m_leave_to_idle();
        else if (btn_stop) m_end_game(sin);
        else if (btn_pause) m_phase = 1;
      end
      default: begin
        if (!enable_game) begin m_phase = 0; m_go = 0; end
      end
    endcase
    for (int i = 0; i < 16; i++) m_led[i] = (m_timer > i) && (i < T_MAX);
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".state"}, state, m_phase);
    chk({ph, ".timer"}, timer, m_timer);
    chk({ph, ".seg_out"}, seg_out, m_sum & 16'hFFFF);
    chk({ph, ".led_out"}, led_out, m_led);
    chk({ph, ".gameover"}, gameover, m_go);
    chk({ph, ".score_final"}, score_final, m_final);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  task automatic set_ch(input int idx, input int val);
    score_in[idx*SCORE_W +: SCORE_W] = SCORE_W'(val);
  endtask

  task automatic pump_rewards(input int n, input string ph);
    for (int k = 0; k < n; k++) begin
      reward_addtime = 1'b1; step(ph);
      reward_addtime = 1'b0; step(ph);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable_game = 1'b0; btn_stop = 1'b0; btn_pause = 1'b0;
    btn_return = 1'b0; reward_addtime = 1'b0; score_in = '0;
    step("rst"); step("rst");
    chk("rst.state_const", state, 2'd0);
    chk("rst.timer_const", timer, 6'd3);
    chk("rst.led_const", led_out, 16'd0);

    // Plain countdown: 3,2,1 every TICK_DIV cycles, then over.
    rst_n = 1'b1; step("idle");
    enable_game = 1'b1; step("cd");
    chk("cd.start_timer", timer, 6'd3);
    repeat (4) step("cd");
    chk("cd.timer2", timer, 6'd2);
    repeat (8) step("cd");
    chk("cd.over_state", state, 2'd3);
    chk("cd.over_go", gameover, 1'b1);
    chk("cd.over_final", score_final, 9'd0);
    chk("cd.over_timer", timer, 6'd3);
    enable_game = 1'b0; step("cd");

    // Milestones on a ramp 0->5->6->10.
    enable_game = 1'b1; step("ms");
    pump_rewards(3, "ms");
    set_ch(0, 5);  step("ms"); step("ms");
    set_ch(0, 6);  step("ms"); step("ms");
    set_ch(0, 10); step("ms"); step("ms"); step("ms");

    // Jump 4->12 across two multiples.
    enable_game = 1'b0; step("jmp");
    set_ch(0, 4); enable_game = 1'b1; step("jmp");
    pump_rewards(2, "jmp");
    set_ch(0, 12); repeat (4) step("jmp");

    // Saturation and a held reward level.
    pump_rewards(4, "sat");
    reward_addtime = 1'b1;
    repeat (100) step("hold");
    reward_addtime = 1'b0; enable_game = 1'b0; step("hold");

    // Pause: frozen timer, ignored reward, resume.
    set_ch(0, 0); enable_game = 1'b1; step("pz");
    pump_rewards(2, "pz");
    step("pz");
    btn_pause = 1'b1; step("pz"); btn_pause = 1'b0;
    repeat (3) step("pz");
    pump_rewards(1, "pz");
    set_ch(1, 9); repeat (3) step("pz");
    btn_pause = 1'b1; step("pz"); btn_pause = 1'b0;
    repeat (6) step("pz");

    // Stop with bonuses pending, then idle and return.
    enable_game = 1'b0; step("stop");
    set_ch(0, 7); set_ch(1, 0); enable_game = 1'b1; step("stop");
    pump_rewards(1, "stop");
    set_ch(1, 8); reward_addtime = 1'b1; btn_stop = 1'b1; step("stop");
    btn_stop = 1'b0; reward_addtime = 1'b0;
    chk("stop.state_const", state, 2'd3);
    chk("stop.final_const", score_final, 9'd15);
    step("stop");
    enable_game = 1'b0; step("stop");
    btn_return = 1'b1; step("stop"); btn_return = 1'b0;
    chk("ret.seg_const", seg_out, 16'd0);
    chk("ret.final_const", score_final, 9'd15);
    chk("ret.go_const", gameover, 1'b0);

    // Reset mid-run.
    enable_game = 1'b1; step("mrst");
    pump_rewards(2, "mrst");
    rst_n = 1'b0; step("mrst");
    chk("mrst.state_const", state, 2'd0);
    chk("mrst.seg_const", seg_out, 16'd0);
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      int idx, nv;
      rst_n       = ($urandom_range(0, 999) != 0);
      enable_game = ($urandom_range(0, 99) < 97);
      btn_stop    = ($urandom_range(0, 199) == 0);
      btn_pause   = ($urandom_range(0, 39) == 0);
      btn_return  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) reward_addtime = ~reward_addtime;
      if ($urandom_range(0, 49) == 0) score_in = '0;
      else if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, NUM_CH - 1);
        nv  = int'(score_in[idx*SCORE_W +: SCORE_W]) + $urandom_range(0, 7);
        set_ch(idx, (nv > 127) ? 0 : nv);
      end
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
